// File: rtl/next_control_sequencer.sv
// Control-word sequencer: decodes one opcode per cycle into registered control outputs, with LDM immediate and flush bubbles.
// Optional interrupt servicing is enabled by defining CU_IRQ_EN; by default the irq input is ignored.
module next_control_sequencer #(
  parameter int OPW       = 5,
  parameter int FLUSH_W   = 2,
  parameter int RET_FLUSH = 2,
  parameter int RTI_FLUSH = 3,
  parameter int INT_FLUSH = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_instr_valid,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_stall,
  input  logic           i_nop_in,
  input  logic           i_irq,
  output logic [9:0]     o_ctrl,
  output logic [3:0]     o_alu_op,
  output logic           o_shift,
  output logic           o_imm_phase,
  output logic           o_pc_hold,
  output logic           o_busy
);

  localparam logic [OPW-1:0] OP_NOT  = OPW'(1);
  localparam logic [OPW-1:0] OP_INC  = OPW'(2);
  localparam logic [OPW-1:0] OP_DEC  = OPW'(3);
  localparam logic [OPW-1:0] OP_MOV  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
  localparam logic [OPW-1:0] OP_AND  = OPW'(7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(9);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(10);
  localparam logic [OPW-1:0] OP_PUSH = OPW'(11);
  localparam logic [OPW-1:0] OP_POP  = OPW'(12);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(13);
  localparam logic [OPW-1:0] OP_IN   = OPW'(14);
  localparam logic [OPW-1:0] OP_SETC = OPW'(15);
  localparam logic [OPW-1:0] OP_CLRC = OPW'(16);
  localparam logic [OPW-1:0] OP_LDD  = OPW'(17);
  localparam logic [OPW-1:0] OP_STD  = OPW'(18);
  localparam logic [OPW-1:0] OP_LDM  = OPW'(19);
  localparam logic [OPW-1:0] OP_JZ   = OPW'(20);
  localparam logic [OPW-1:0] OP_JN   = OPW'(21);
  localparam logic [OPW-1:0] OP_JC   = OPW'(22);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(23);
  localparam logic [OPW-1:0] OP_CALL = OPW'(24);
  localparam logic [OPW-1:0] OP_RET  = OPW'(25);
  localparam logic [OPW-1:0] OP_RTI  = OPW'(26);
  localparam logic [OPW-1:0] OP_INT  = OPW'(27);

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_NOT = 4'd1;
  localparam logic [3:0] ALU_INC = 4'd2;
  localparam logic [3:0] ALU_DEC = 4'd3;
  localparam logic [3:0] ALU_MOV = 4'd4;
  localparam logic [3:0] ALU_ADD = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_AND = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;
  localparam logic [3:0] ALU_SHL = 4'd9;
  localparam logic [3:0] ALU_SHR = 4'd10;

  // {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
  localparam logic [9:0] ALU_SIGNALS    = 10'b0000001000;
  localparam logic [9:0] BRANCH_SIGNALS = 10'b0000000100;
  localparam logic [9:0] INT_SIGNALS    = 10'b0001000100;
  localparam logic [9:0] IMM_SIGNALS    = 10'b0000011000;

  localparam int FMAX = (1 << FLUSH_W) - 1;
  localparam logic [FLUSH_W-1:0] RET_LD = FLUSH_W'((RET_FLUSH > FMAX) ? FMAX : RET_FLUSH);
  localparam logic [FLUSH_W-1:0] RTI_LD = FLUSH_W'((RTI_FLUSH > FMAX) ? FMAX : RTI_FLUSH);
  localparam logic [FLUSH_W-1:0] INT_LD = FLUSH_W'((INT_FLUSH > FMAX) ? FMAX : INT_FLUSH);

  // S_DECODE: issue opcodes | S_IMM: LDM immediate cycle | S_FLUSH: pc_hold bubbles
  typedef enum logic [1:0] {S_DECODE, S_IMM, S_FLUSH} state_t;

  state_t             r_state, w_state_n;
  logic [FLUSH_W-1:0] r_cnt, w_cnt_n, w_ld_val;
  logic               r_pend, w_pend_n, w_irq_take, w_service, w_do_ld;
  logic [9:0]         r_ctrl, w_ctrl_n;
  logic [3:0]         r_alu, w_alu_n;
  logic               r_shift, w_shift_n;
  logic               r_imm, w_imm_n;
  logic               r_pch, w_pch_n;
  logic               r_busy, w_busy_n;

  assign w_irq_take = r_pend;

`ifndef CU_IRQ_EN
  logic w_unused_irq;
  assign w_unused_irq = i_irq;
`endif

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pend_n  = r_pend;
    w_ctrl_n  = r_ctrl;
    w_alu_n   = r_alu;
    w_shift_n = r_shift;
    w_imm_n   = r_imm;
    w_pch_n   = r_pch;
    w_busy_n  = r_busy;
    w_service = 1'b0;
    w_do_ld   = 1'b0;
    w_ld_val  = '0;
    if (!i_stall) begin
      w_ctrl_n  = '0;
      w_alu_n   = ALU_NOP;
      w_shift_n = 1'b0;
      w_imm_n   = 1'b0;
      w_pch_n   = 1'b0;
      w_busy_n  = (r_state != S_DECODE);
      case (r_state)
        S_IMM: begin
          w_ctrl_n  = IMM_SIGNALS;
          w_alu_n   = ALU_MOV;
          w_imm_n   = 1'b1;
          w_state_n = S_DECODE;
        end
        S_FLUSH: begin
          w_pch_n = 1'b1;
          w_cnt_n = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
          if (r_cnt <= FLUSH_W'(1)) w_state_n = S_DECODE;
        end
        default: begin
          if (w_irq_take) begin
            w_ctrl_n  = INT_SIGNALS;
            w_service = 1'b1;
            w_do_ld   = 1'b1;
            w_ld_val  = INT_LD;
          end else if (i_instr_valid && !i_nop_in) begin
            case (i_opcode)
              OP_NOT:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_NOT; end
              OP_INC:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_INC; end
              OP_DEC:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_DEC; end
              OP_MOV:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_MOV; end
              OP_ADD:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_ADD; end
              OP_SUB:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_SUB; end
              OP_AND:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_AND; end
              OP_OR:   begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_OR;  end
              OP_SHL:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_SHL; w_shift_n = 1'b1; end
              OP_SHR:  begin w_ctrl_n = ALU_SIGNALS; w_alu_n = ALU_SHR; w_shift_n = 1'b1; end
              OP_PUSH, OP_STD: w_ctrl_n = 10'b0001000000;
              OP_POP,  OP_LDD: w_ctrl_n = 10'b0010101000;
              OP_OUT:  begin w_ctrl_n = 10'b0100000000; w_alu_n = ALU_MOV; end
              OP_IN:   begin w_ctrl_n = 10'b1000001000; w_alu_n = ALU_MOV; end
              OP_SETC: w_ctrl_n = 10'b0000000010;
              OP_CLRC: w_ctrl_n = 10'b0000000001;
              OP_JZ, OP_JN, OP_JC, OP_JMP, OP_CALL: w_ctrl_n = BRANCH_SIGNALS;
              OP_LDM:  w_state_n = S_IMM;
              OP_RET:  begin w_ctrl_n = BRANCH_SIGNALS; w_do_ld = 1'b1; w_ld_val = RET_LD; end
              OP_RTI:  begin w_ctrl_n = BRANCH_SIGNALS; w_do_ld = 1'b1; w_ld_val = RTI_LD; end
              OP_INT:  begin w_ctrl_n = INT_SIGNALS;    w_do_ld = 1'b1; w_ld_val = INT_LD; end
              default: w_ctrl_n = '0;
            endcase
          end
        end
      endcase
      if (w_do_ld && (w_ld_val != '0)) begin
        w_cnt_n   = w_ld_val;
        w_state_n = S_FLUSH;
      end
`ifdef CU_IRQ_EN
      w_pend_n = (r_pend && !w_service) || i_irq;
`else
      w_pend_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_DECODE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_ctrl  <= '0;
      r_alu   <= ALU_NOP;
      r_shift <= 1'b0;
      r_imm   <= 1'b0;
      r_pch   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= w_pend_n;
      r_ctrl  <= w_ctrl_n;
      r_alu   <= w_alu_n;
      r_shift <= w_shift_n;
      r_imm   <= w_imm_n;
      r_pch   <= w_pch_n;
      r_busy  <= w_busy_n;
    end
  end

  assign o_ctrl      = r_ctrl;
  assign o_alu_op    = r_alu;
  assign o_shift     = r_shift;
  assign o_imm_phase = r_imm;
  assign o_pc_hold   = r_pch;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_next_control_sequencer.sv
// Scoreboard bench for next_control_sequencer: stimulus queues expected outputs, a monitor compares after each edge.
module tb_next_control_sequencer;

  localparam logic [4:0] OP_NOT = 5'd1,  OP_INC = 5'd2,  OP_DEC = 5'd3,  OP_MOV = 5'd4;
  localparam logic [4:0] OP_ADD = 5'd5,  OP_SUB = 5'd6,  OP_AND = 5'd7,  OP_OR = 5'd8;
  localparam logic [4:0] OP_SHL = 5'd9,  OP_SHR = 5'd10, OP_PUSH = 5'd11, OP_POP = 5'd12;
  localparam logic [4:0] OP_OUT = 5'd13, OP_IN = 5'd14,  OP_SETC = 5'd15, OP_CLRC = 5'd16;
  localparam logic [4:0] OP_LDD = 5'd17, OP_STD = 5'd18, OP_LDM = 5'd19,  OP_JZ = 5'd20;
  localparam logic [4:0] OP_JN = 5'd21,  OP_JC = 5'd22,  OP_JMP = 5'd23,  OP_CALL = 5'd24;
  localparam logic [4:0] OP_RET = 5'd25, OP_RTI = 5'd26, OP_INT = 5'd27;

  localparam logic [9:0] C_ALU = 10'b0000001000;
  localparam logic [9:0] C_BR  = 10'b0000000100;
  localparam logic [9:0] C_INT = 10'b0001000100;
  localparam logic [9:0] C_IMM = 10'b0000011000;

  typedef struct {
    string      nm;
    logic [9:0] c;
    logic [3:0] a;
    logic       s, im, ph, b;
  } exp_t;

  logic       clk, rst, vld, stall, nop_in, irq;
  logic [4:0] opcode;
  logic [9:0] ctrl;
  logic [3:0] alu_op;
  logic       shift, imm_phase, pc_hold, busy;

  exp_t q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_pass   = 0;

  next_control_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(vld), .i_opcode(opcode),
    .i_stall(stall), .i_nop_in(nop_in), .i_irq(irq),
    .o_ctrl(ctrl), .o_alu_op(alu_op), .o_shift(shift),
    .o_imm_phase(imm_phase), .o_pc_hold(pc_hold), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [9:0] c, input logic [3:0] a,
                              input logic s, input logic im, input logic ph, input logic b);
    exp_t e;
    e.nm = ""; e.c = c; e.a = a; e.s = s; e.im = im; e.ph = ph; e.b = b;
    return e;
  endfunction

  task automatic step(input string nm, input logic r, input logic v, input logic [4:0] op,
                      input logic st, input logic np, input logic iq, input exp_t e);
    @(negedge clk);
    rst = r; vld = v; opcode = op; stall = st; nop_in = np; irq = iq;
    e.nm = nm;
    q.push_back(e);
    last = e;
  endtask

  task automatic go(input string nm, input logic [4:0] op, input exp_t e);
    step(nm, 1'b0, 1'b1, op, 1'b0, 1'b0, 1'b0, e);
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (ctrl === e.c && alu_op === e.a && shift === e.s && imm_phase === e.im &&
            pc_hold === e.ph && busy === e.b)
          n_pass++;
        else
          $display("FAIL %s: got ctrl=%b alu=%0d shift=%b imm=%b pc_hold=%b busy=%b, want ctrl=%b alu=%0d shift=%b imm=%b pc_hold=%b busy=%b",
                   e.nm, ctrl, alu_op, shift, imm_phase, pc_hold, busy,
                   e.c, e.a, e.s, e.im, e.ph, e.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] alu_ops [10];
    logic [3:0] alu_codes [10];
    exp_t NOP, BUB, IMM, RST;
    alu_ops   = '{OP_NOT, OP_INC, OP_DEC, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR};
    alu_codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    NOP = mk(10'b0, 4'd0, 0, 0, 0, 0);
    RST = NOP;
    BUB = mk(10'b0, 4'd0, 0, 0, 1, 1);
    IMM = mk(C_IMM, 4'd4, 0, 1, 0, 1);
    rst = 1'b1; vld = 1'b0; opcode = 5'd0; stall = 1'b0; nop_in = 1'b0; irq = 1'b0;

    step("rst_a", 1, 1, OP_ADD, 0, 0, 0, RST);
    step("rst_b_stall", 1, 1, OP_ADD, 1, 0, 0, RST);
    go("add_after_rst", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));
    step("shr_nop_in", 0, 1, OP_SHR, 0, 1, 0, NOP);
    go("shr", OP_SHR, mk(C_ALU, 4'd10, 1, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      go($sformatf("alu_class_%0d", i), alu_ops[i], mk(C_ALU, alu_codes[i], (i >= 8), 0, 0, 0));
    step("invalid", 0, 0, OP_ADD, 0, 0, 0, NOP);
    go("unlisted", 5'd30, NOP);
    go("push", OP_PUSH, mk(10'b0001000000, 4'd0, 0, 0, 0, 0));
    go("std",  OP_STD,  mk(10'b0001000000, 4'd0, 0, 0, 0, 0));
    go("pop",  OP_POP,  mk(10'b0010101000, 4'd0, 0, 0, 0, 0));
    go("ldd",  OP_LDD,  mk(10'b0010101000, 4'd0, 0, 0, 0, 0));
    go("out",  OP_OUT,  mk(10'b0100000000, 4'd4, 0, 0, 0, 0));
    go("in",   OP_IN,   mk(10'b1000001000, 4'd4, 0, 0, 0, 0));
    go("setc", OP_SETC, mk(10'b0000000010, 4'd0, 0, 0, 0, 0));
    go("clrc", OP_CLRC, mk(10'b0000000001, 4'd0, 0, 0, 0, 0));
    go("jz",   OP_JZ,   mk(C_BR, 4'd0, 0, 0, 0, 0));
    go("jn",   OP_JN,   mk(C_BR, 4'd0, 0, 0, 0, 0));
    go("jc",   OP_JC,   mk(C_BR, 4'd0, 0, 0, 0, 0));
    go("jmp",  OP_JMP,  mk(C_BR, 4'd0, 0, 0, 0, 0));
    go("call", OP_CALL, mk(C_BR, 4'd0, 0, 0, 0, 0));
    step("stall_hold", 0, 1, OP_ADD, 1, 0, 0, last);
    go("after_stall", OP_SUB, mk(C_ALU, 4'd6, 0, 0, 0, 0));

    go("ldm", OP_LDM, NOP);
    step("imm_phase", 0, 1, OP_ADD, 0, 1, 0, IMM);
    go("post_imm", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));

    go("rti", OP_RTI, mk(C_BR, 4'd0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) go($sformatf("rti_bubble_%0d", i), OP_ADD, BUB);
    go("post_rti", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));

    go("ret", OP_RET, mk(C_BR, 4'd0, 0, 0, 0, 0));
    step("ret_stall_a", 0, 1, OP_ADD, 1, 0, 0, last);
    step("ret_stall_b", 0, 1, OP_ADD, 1, 0, 0, last);
    for (int i = 0; i < 2; i++) go($sformatf("ret_bubble_%0d", i), OP_ADD, BUB);
    go("post_ret", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));

    go("int_op", OP_INT, mk(C_INT, 4'd0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) go($sformatf("int_bubble_%0d", i), OP_ADD, BUB);
    go("post_int", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));

    go("rti_mid", OP_RTI, mk(C_BR, 4'd0, 0, 0, 0, 0));
    go("rti_mid_bubble", OP_ADD, BUB);
    step("rst_mid_flush", 1, 1, OP_ADD, 1, 0, 0, RST);
    go("post_rst_mid", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));

    go("ldm_irq", OP_LDM, NOP);
    step("imm_irq", 0, 1, OP_ADD, 0, 0, 1, IMM);
`ifdef CU_IRQ_EN
    go("irq_int", OP_ADD, mk(C_INT, 4'd0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) go($sformatf("irq_bubble_%0d", i), OP_ADD, BUB);
    go("post_irq", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));
`else
    go("irq_ignored", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));
    step("irq_in_decode", 0, 1, OP_SUB, 0, 0, 1, mk(C_ALU, 4'd6, 0, 0, 0, 0));
    go("irq_still_ignored", OP_ADD, mk(C_ALU, 4'd5, 0, 0, 0, 0));
`endif

    @(negedge clk);
    vld = 1'b0; irq = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/next_control_sequencer.md
NEXT_CONTROL_SEQUENCER -- requirements
Module: next_control_sequencer

Parameters
REQ-001 SHALL provide OPW, default 5, opcode width.
REQ-002 SHALL provide FLUSH_W, default 2, flush-counter width.
REQ-003 SHALL provide RET_FLUSH, default 2, bubbles after RET (0 = none).
REQ-004 SHALL provide RTI_FLUSH, default 3, bubbles after RTI (0 = none).
REQ-005 SHALL provide INT_FLUSH, default 3, bubbles after INT or IRQ entry (0 = none).

Interface
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have: instr_valid  in  1  opcode valid this cycle (0 = treat as NOP).
REQ-008 SHALL have: opcode  in  OPW  opcode from the decode stage, encodings per the project defines header.
REQ-009 SHALL have: stall  in  1  hazard-unit freeze.
REQ-010 SHALL have: nop_in  in  1  hazard-unit bubble request.
REQ-011 SHALL have: irq  in  1  external interrupt, level.
REQ-012 SHALL have: ctrl  out  10  {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}.
REQ-013 SHALL have: alu_op  out  4  ALU operation code.
REQ-014 SHALL have: shift  out  1  current op is SHL/SHR.
REQ-015 SHALL have: imm_phase  out  1  second (immediate) cycle of LDM.
REQ-016 SHALL have: pc_hold  out  1  hold fetch PC (flush bubble).
REQ-017 SHALL have: busy  out  1  state is not DECODE.

Function
REQ-018 SHALL register all outputs, one-cycle latency opcode -> ctrl/alu_op/shift.
REQ-019 SHALL implement states DECODE, IMM, FLUSH.
REQ-020 Priority SHALL be rst > stall > IMM/FLUSH sequencing > pending IRQ > nop_in > opcode decode.
REQ-021 stall=1 SHALL hold state, counter, pending-IRQ flag and all outputs unchanged.
REQ-022 In DECODE, nop_in=1, instr_valid=0 or an unlisted opcode SHALL emit a NOP: ctrl=0, ALU_NOP, shift=0.
REQ-023 ALU class opcodes (NOT, INC, DEC, MOV, ADD, SUB, AND, OR, SHL, SHR) SHALL emit ALU_SIGNALS with the matching ALU code; shift=1 only for SHL/SHR.
REQ-024 PUSH/STD SHALL emit 0001000000; POP/LDD SHALL emit 0010101000; OUT 0100000000/MOV; IN 1000001000/MOV; SETC 0000000010; CLRC 0000000001.
REQ-025 JZ/JN/JC/JMP/CALL SHALL emit BRANCH_SIGNALS/ALU_NOP and stay in DECODE.
REQ-026 LDM SHALL emit NOP and go to IMM; IMM SHALL emit 0000011000, ALU_MOV, imm_phase=1, then return to DECODE; nop_in is ignored in IMM.
REQ-027 RET/RTI SHALL emit BRANCH_SIGNALS, load the counter with RET_FLUSH/RTI_FLUSH and go to FLUSH if the value is nonzero.
REQ-028 FLUSH SHALL emit NOP with pc_hold=1 and decrement each cycle, returning to DECODE when the count reaches 0; exactly N bubbles for N.
REQ-029 INT opcode SHALL emit 0001000100, ALU_NOP and enter FLUSH with INT_FLUSH.
REQ-030 The counter SHALL saturate its load at 2^FLUSH_W-1.

Reset
REQ-031 rst SHALL force DECODE, counter=0, pending IRQ=0, ctrl=0, alu_op=ALU_NOP, shift=0, imm_phase=0, pc_hold=0, busy=0; it overrides stall and applies mid-IMM/FLUSH.

Configuration
REQ-032 Macro CU_IRQ_EN: when defined, irq sets a pending flag; in DECODE, when not stalled, a pending IRQ SHALL emit the INT control word, clear the flag and enter FLUSH with INT_FLUSH, deferring the current opcode; irq raised during IMM/FLUSH SHALL be serviced on the first DECODE cycle after. When undefined, the irq port SHALL exist but be ignored.

Verification
REQ-033 rst held 2 cycles, opcode=ADD -> all outputs at reset values; the cycle after release, ctrl=ALU_SIGNALS, alu_op=ALU_ADD.
REQ-034 LDM then any opcode -> cycle1 ctrl=0; cycle2 ctrl=0000011000, ALU_MOV, imm_phase=1, following opcode ignored.
REQ-035 RTI, RTI_FLUSH=3 -> branch word, then exactly 3 NOP cycles with pc_hold=1, busy=1, then DECODE.
REQ-036 RET during FLUSH with stall=1 for 2 cycles -> counter frozen, total bubble count still 2.
REQ-037 CU_IRQ_EN defined, irq pulse during IMM -> LDM completes, next cycle ctrl=0001000100, then 3 bubbles.
REQ-038 opcode=SHR, nop_in=1 -> NOP, shift=0; next cycle with nop_in=0 -> ALU_SHR, shift=1.
